// File: rtl/vga_pkg.sv
// Resolution constants, colour width and FSM encoding shared by the framebuffer writer.
package vga_pkg;
`ifdef VGA_640_480
   localparam int COLS = 640;
   localparam int ROWS = 480;
   localparam int n    = 10;
   localparam int AW   = 19;
`elsif VGA_320_240
   localparam int COLS = 320;
   localparam int ROWS = 240;
   localparam int n    = 9;
   localparam int AW   = 17;
`else
   localparam int COLS = 160;
   localparam int ROWS = 120;
   localparam int n    = 8;
   localparam int AW   = 15;
`endif
   localparam int CW = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;
endpackage

// File: rtl/vga_pixel_fifo.sv
// Synchronous FIFO; dout shows the head combinationally. Full push is allowed only alongside a pop.
module vga_pixel_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 18
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

   logic [W-1:0] r_mem [DEPTH];
   logic [PW:0]  r_wr;
   logic [PW:0]  r_rd;
   logic         w_push;
   logic         w_pop;

   assign empty  = (r_wr == r_rd);
   assign full   = (r_wr[PW] != r_rd[PW]) && (r_wr[PW-1:0] == r_rd[PW-1:0]);
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);
   assign dout   = r_mem[r_rd[PW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + PTR_ONE;
         if (w_pop)  r_rd <= r_rd + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr[PW-1:0]] <= din;
   end
endmodule

// File: rtl/vga_fb_writer.sv
// Turns the (x,y,colour,plot) stream into framebuffer writes with off-screen drop and hardware clear.
// Pixel to fb_we: two edges; fb_stall freezes the output register, FIFO fill then drops ready.
module vga_fb_writer
   import vga_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   input  logic [n-1:0]  VGA_X,
   input  logic [n-2:0]  VGA_Y,
   input  logic [CW-1:0] VGA_COLOR,
   input  logic          plot,
   output logic          ready,
   input  logic          clear,
   input  logic [CW-1:0] clear_color,
   output logic          busy,
   output logic          dropped,
   output logic [AW-1:0] fb_addr,
   output logic [CW-1:0] fb_data,
   output logic          fb_we,
   input  logic          fb_stall
);
   localparam logic [n-1:0]  X_LIM   = n'(COLS);
   localparam logic [n-2:0]  Y_LIM   = (n-1)'(ROWS);
   localparam logic [AW-1:0] COLS_A  = AW'(COLS);
   localparam logic [AW-1:0] LAST_A  = AW'(COLS*ROWS-1);
   localparam logic [AW:0]   LAST_C  = (AW+1)'(COLS*ROWS-1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_we;
   logic [AW-1:0]   r_addr;
   logic [CW-1:0]   r_data;
   logic            r_drop;
   logic            r_clr_pend;
   logic [CW-1:0]   r_ccol;
   logic [AW:0]     r_cnt;

   logic            w_accept;
   logic            w_onscreen;
   logic            w_push;
   logic            w_pop;
   logic            w_out_free;
   logic            w_consume;
   logic            w_fill_start;
   logic            w_fill_load;
   logic            w_fill_end;
   logic [AW-1:0]   w_addr;
   logic [AW+CW-1:0] w_fifo_dout;
   logic            w_fifo_full;
   logic            w_fifo_empty;

   assign w_onscreen = (VGA_X < X_LIM) && (VGA_Y < Y_LIM);
   assign w_accept   = plot && ready;
   assign w_push     = w_accept && w_onscreen;
   assign w_addr     = AW'(VGA_Y) * COLS_A + AW'(VGA_X);
   assign w_consume  = r_we && !fb_stall;
   assign w_out_free = !r_we || !fb_stall;

   vga_pixel_fifo #(
      .DEPTH (DEPTH),
      .W     (AW+CW)
   ) u_fifo (
      .clk   (CLOCK_50),
      .reset (reset),
      .push  (w_push),
      .pop   (w_pop),
      .din   ({w_addr, VGA_COLOR}),
      .dout  (w_fifo_dout),
      .full  (w_fifo_full),
      .empty (w_fifo_empty)
   );

   always_ff @(posedge CLOCK_50) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_fill_start) w_state_nxt = ST_CLEAR;
         ST_CLEAR: if (w_fill_end)   w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_pop        = 1'b0;
      w_fill_start = 1'b0;
      w_fill_load  = 1'b0;
      w_fill_end   = 1'b0;
      ready        = !w_fifo_full && (r_state == ST_IDLE) && !r_clr_pend;
      busy         = !w_fifo_empty || r_we || r_clr_pend || (r_state == ST_CLEAR);
      case (r_state)
         ST_IDLE: begin
            w_pop        = w_out_free && !w_fifo_empty;
            w_fill_start = w_out_free && w_fifo_empty && r_clr_pend;
         end
         ST_CLEAR: begin
            w_fill_load = w_out_free && (r_cnt <= LAST_C);
            w_fill_end  = w_consume && (r_addr == LAST_A);
         end
         default: ;
      endcase
   end

   // The fill loads address 0 on the entry edge so the clear starts without a bubble.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_drop     <= 1'b0;
         r_clr_pend <= 1'b0;
         r_ccol     <= '0;
         r_cnt      <= '0;
      end else begin
         r_drop <= w_accept && !w_onscreen;
         if ((r_state == ST_IDLE) && !r_clr_pend && clear) begin
            r_clr_pend <= 1'b1;
            r_ccol     <= clear_color;
         end else if (w_fill_end) begin
            r_clr_pend <= 1'b0;
         end
         if (w_pop) begin
            r_we             <= 1'b1;
            {r_addr, r_data} <= w_fifo_dout;
         end else if (w_fill_start) begin
            r_we   <= 1'b1;
            r_addr <= '0;
            r_data <= r_ccol;
            r_cnt  <= CNT_ONE;
         end else if (w_fill_load) begin
            r_we   <= 1'b1;
            r_addr <= r_cnt[AW-1:0];
            r_cnt  <= r_cnt + CNT_ONE;
         end else if (w_consume) begin
            r_we <= 1'b0;
         end
      end
   end

   assign fb_we   = r_we;
   assign fb_addr = r_addr;
   assign fb_data = r_data;
   assign dropped = r_drop;
endmodule

// File: tb/tb_vga_fb_writer.sv
// Directed bench for vga_fb_writer at the default 160x120 resolution.
module tb_vga_fb_writer;
   import vga_pkg::*;

   logic          CLOCK_50 = 1'b0;
   logic          reset = 1'b1;
   logic [n-1:0]  VGA_X = '0;
   logic [n-2:0]  VGA_Y = '0;
   logic [CW-1:0] VGA_COLOR = '0;
   logic          plot = 1'b0;
   logic          ready;
   logic          clear = 1'b0;
   logic [CW-1:0] clear_color = '0;
   logic          busy;
   logic          dropped;
   logic [AW-1:0] fb_addr;
   logic [CW-1:0] fb_data;
   logic          fb_we;
   logic          fb_stall = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   vga_fb_writer #(.DEPTH(4)) dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .VGA_X       (VGA_X),
      .VGA_Y       (VGA_Y),
      .VGA_COLOR   (VGA_COLOR),
      .plot        (plot),
      .ready       (ready),
      .clear       (clear),
      .clear_color (clear_color),
      .busy        (busy),
      .dropped     (dropped),
      .fb_addr     (fb_addr),
      .fb_data     (fb_data),
      .fb_we       (fb_we),
      .fb_stall    (fb_stall)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge CLOCK_50);
      #1;
   endtask

   initial begin
      int n_acc, bad, bad_ctl, wr, cyc, first_a, first_d, second_a, second_d;
      logic stall;

      // reset state
      tick; tick;
      reset = 1'b0;
      check("rst fb_we", fb_we, 0);
      check("rst fb_addr", fb_addr, 0);
      check("rst fb_data", fb_data, 0);
      check("rst dropped", dropped, 0);
      check("rst busy", busy, 0);
      check("rst ready", ready, 1);

      // single pixel latency and address
      plot = 1'b1; VGA_X = 8'd5; VGA_Y = 7'd2; VGA_COLOR = 3'd3;
      tick;
      plot = 1'b0;
      check("px1 we early", fb_we, 0);
      tick;
      check("px1 we", fb_we, 1);
      check("px1 addr", fb_addr, 325);
      check("px1 data", fb_data, 3);
      tick;
      check("px1 we done", fb_we, 0);
      check("px1 busy done", busy, 0);

      // off-screen pixels
      plot = 1'b1; VGA_X = 8'd160; VGA_Y = 7'd0;
      tick;
      VGA_X = 8'd0; VGA_Y = 7'd120;
      check("drop x pulse", dropped, 1);
      check("drop x busy", busy, 0);
      tick;
      plot = 1'b0;
      check("drop y pulse", dropped, 1);
      check("drop y we", fb_we, 0);
      tick;
      check("drop end", dropped, 0);
      check("drop no we", fb_we, 0);
      check("drop fifo empty", busy, 0);

      // capacity under stall, then ordered drain
      fb_stall = 1'b1;
      n_acc = 0;
      for (int i = 0; i < 6; i++) begin
         plot = 1'b1; VGA_X = n'(i); VGA_Y = '0; VGA_COLOR = 3'(i + 1);
         if (ready) n_acc++;
         tick;
      end
      plot = 1'b0;
      check("stall accepted", n_acc, 5);
      check("stall ready", ready, 0);
      check("stall we held", fb_we, 1);
      check("stall addr held", fb_addr, 0);
      fb_stall = 1'b0;
      for (int j = 0; j < 5; j++) begin
         check("drain we", fb_we, 1);
         check("drain addr", fb_addr, j);
         check("drain data", fb_data, j + 1);
         tick;
      end
      check("drain we end", fb_we, 0);
      check("drain ready", ready, 1);
      check("drain busy", busy, 0);

      // full clear with random stalls
      clear = 1'b1; clear_color = 3'd2;
      tick;
      clear = 1'b0;
      check("clr ready", ready, 0);
      check("clr busy", busy, 1);
      wr = 0; bad = 0; bad_ctl = 0; cyc = 0;
      while (wr < 19200 && cyc < 60000) begin
         stall = ($urandom_range(0, 3) == 0);
         fb_stall = stall;
         if (ready || !busy) bad_ctl++;
         if (fb_we && !stall) begin
            if (fb_addr != AW'(wr) || fb_data != 3'd2) bad++;
            wr++;
         end
         tick;
         cyc++;
      end
      fb_stall = 1'b0;
      check("clr writes", wr, 19200);
      check("clr addr/data errors", bad, 0);
      check("clr ready/busy errors", bad_ctl, 0);
      check("clr done ready", ready, 1);
      check("clr done busy", busy, 0);
      check("clr done we", fb_we, 0);

      // pixel plus clear on one edge; second clear mid-fill is ignored
      plot = 1'b1; VGA_X = 8'd10; VGA_Y = 7'd10; VGA_COLOR = 3'd7;
      clear = 1'b1; clear_color = 3'd1;
      check("pc ready", ready, 1);
      tick;
      plot = 1'b0; clear = 1'b0;
      wr = 0; bad = 0; cyc = 0;
      first_a = -1; first_d = -1; second_a = -1; second_d = -1;
      while (wr < 19201 && cyc < 40000) begin
         clear = (cyc == 50);
         clear_color = (cyc == 50) ? 3'd4 : 3'd1;
         if (fb_we) begin
            if (wr == 0) begin
               first_a = int'(fb_addr); first_d = int'(fb_data);
            end else begin
               if (wr == 1) begin
                  second_a = int'(fb_addr); second_d = int'(fb_data);
               end
               if (fb_addr != AW'(wr - 1) || fb_data != 3'd1) bad++;
            end
            wr++;
         end
         tick;
         cyc++;
      end
      clear = 1'b0;
      check("pc first addr", first_a, 1610);
      check("pc first data", first_d, 7);
      check("pc fill start addr", second_a, 0);
      check("pc fill start data", second_d, 1);
      check("pc writes", wr, 19201);
      check("pc fill errors", bad, 0);
      wr = 0;
      for (int k = 0; k < 20; k++) begin
         if (fb_we) wr++;
         tick;
      end
      check("pc no refill", wr, 0);
      check("pc idle busy", busy, 0);

      // reset in the middle of a clear
      clear = 1'b1; clear_color = 3'd5;
      tick;
      clear = 1'b0;
      cyc = 0;
      while (!(fb_we && fb_addr == AW'(100)) && cyc < 500) begin
         tick;
         cyc++;
      end
      check("mid reach 100", int'(fb_we && fb_addr == AW'(100)), 1);
      reset = 1'b1;
      tick;
      check("mid rst we", fb_we, 0);
      check("mid rst addr", fb_addr, 0);
      check("mid rst data", fb_data, 0);
      check("mid rst busy", busy, 0);
      check("mid rst ready", ready, 1);
      check("mid rst dropped", dropped, 0);
      reset = 1'b0;
      wr = 0;
      for (int k = 0; k < 30; k++) begin
         if (fb_we) wr++;
         tick;
      end
      check("mid no writes", wr, 0);
      check("mid busy after", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
